mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported synchronous memory between an
// instruction-fetch port (read only) and a data port (read/write). Each port
// owns a one-deep pending buffer; a three-state FSM issues one access at a
// time and returns read data after LAT cycles.
module mem_port_arbiter #(
    parameter int ADDR_W = 17,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rstn,
    // instruction-fetch port
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_accepted,
    output logic              i_done,
    output logic [31:0]       i_rdata,
    // data port
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_accepted,
    output logic              d_done,
    output logic [31:0]       d_rdata,
    // memory port
    output logic              m_en,
    output logic [3:0]        m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic [2:0] LAT_C = 3'(LAT);

    logic [1:0]        state_q,      state_d;
    logic [2:0]        cnt_q,        cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              cur_port_q,   cur_port_d;

    logic              ib_valid_q,   ib_valid_d;
    logic [ADDR_W-1:0] ib_addr_q,    ib_addr_d;
    logic              i_busy_q,     i_busy_d;

    logic              db_valid_q,   db_valid_d;
    logic [ADDR_W-1:0] db_addr_q,    db_addr_d;
    logic [3:0]        db_we_q,      db_we_d;
    logic [31:0]       db_wdata_q,   db_wdata_d;
    logic              d_busy_q,     d_busy_d;

    logic              m_en_q,       m_en_d;
    logic [3:0]        m_we_q,       m_we_d;
    logic [ADDR_W-1:0] m_addr_q,     m_addr_d;
    logic [31:0]       m_wdata_q,    m_wdata_d;

    logic              i_acc_q,      i_acc_d;
    logic              d_acc_q,      d_acc_d;
    logic              i_done_q,     i_done_d;
    logic              d_done_q,     d_done_d;
    logic [31:0]       i_rdata_q,    i_rdata_d;
    logic [31:0]       d_rdata_q,    d_rdata_d;

    logic              grant_data;

    // Next-state logic: request capture, arbitration and access sequencing.
    always_comb begin
        // NOTE: every _d starts from its _q (or from zero for pulses) so no
        // path through the case statement can leave a latch behind.
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        cur_port_d   = cur_port_q;
        ib_valid_d   = ib_valid_q;
        ib_addr_d    = ib_addr_q;
        i_busy_d     = i_busy_q;
        db_valid_d   = db_valid_q;
        db_addr_d    = db_addr_q;
        db_we_d      = db_we_q;
        db_wdata_d   = db_wdata_q;
        d_busy_d     = d_busy_q;
        m_en_d       = 1'b0;
        m_we_d       = 4'b0000;
        m_addr_d     = '0;
        m_wdata_d    = 32'h0;
        i_acc_d      = 1'b0;
        d_acc_d      = 1'b0;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        grant_data   = 1'b0;

        // A port takes a new request only when it has nothing queued or in flight.
        if (i_req && !ib_valid_q && !i_busy_q) begin
            ib_valid_d = 1'b1;
            ib_addr_d  = i_addr;
            i_acc_d    = 1'b1;
        end
        if (d_req && !db_valid_q && !d_busy_q) begin
            db_valid_d = 1'b1;
            db_addr_d  = d_addr;
            db_we_d    = d_we;
            db_wdata_d = d_wdata;
            d_acc_d    = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (ib_valid_q || db_valid_q) begin
                    grant_data = db_valid_q && (!ib_valid_q || last_grant_q == PORT_I);
                    // Only contested grants move the round-robin pointer, so an
                    // uncontested grant never steals the other port's next tie.
                    if (ib_valid_q && db_valid_q) begin
                        last_grant_d = grant_data;
                    end
                    m_en_d  = 1'b1;
                    state_d = S_ISSUE;
                    if (grant_data) begin
                        cur_port_d = PORT_D;
                        db_valid_d = 1'b0;
                        d_busy_d   = 1'b1;
                        m_we_d     = db_we_q;
                        m_addr_d   = db_addr_q;
                        m_wdata_d  = db_wdata_q;
                    end else begin
                        cur_port_d = PORT_I;
                        ib_valid_d = 1'b0;
                        i_busy_d   = 1'b1;
                        m_addr_d   = ib_addr_q;
                    end
                end
            end
            S_ISSUE: begin
                if (m_we_q != 4'b0000) begin
                    // Writes complete the cycle after the memory strobe.
                    state_d  = S_IDLE;
                    d_done_d = 1'b1;
                    d_busy_d = 1'b0;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = 3'd1;
                end
            end
            S_WAIT: begin
                if (cnt_q == LAT_C) begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                    if (cur_port_q == PORT_D) begin
                        d_rdata_d = m_rdata;
                        d_done_d  = 1'b1;
                        d_busy_d  = 1'b0;
                    end else begin
                        i_rdata_d = m_rdata;
                        i_done_d  = 1'b1;
                        i_busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any access.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rstn) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            last_grant_q <= PORT_I;
            cur_port_q   <= PORT_I;
            ib_valid_q   <= 1'b0;
            ib_addr_q    <= '0;
            i_busy_q     <= 1'b0;
            db_valid_q   <= 1'b0;
            db_addr_q    <= '0;
            db_we_q      <= 4'b0000;
            db_wdata_q   <= 32'h0;
            d_busy_q     <= 1'b0;
            m_en_q       <= 1'b0;
            m_we_q       <= 4'b0000;
            m_addr_q     <= '0;
            m_wdata_q    <= 32'h0;
            i_acc_q      <= 1'b0;
            d_acc_q      <= 1'b0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
            i_rdata_q    <= 32'h0;
            d_rdata_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            cur_port_q   <= cur_port_d;
            ib_valid_q   <= ib_valid_d;
            ib_addr_q    <= ib_addr_d;
            i_busy_q     <= i_busy_d;
            db_valid_q   <= db_valid_d;
            db_addr_q    <= db_addr_d;
            db_we_q      <= db_we_d;
            db_wdata_q   <= db_wdata_d;
            d_busy_q     <= d_busy_d;
            m_en_q       <= m_en_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            i_acc_q      <= i_acc_d;
            d_acc_q      <= d_acc_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign i_accepted = i_acc_q;
    assign i_done     = i_done_q;
    assign i_rdata    = i_rdata_q;
    assign d_accepted = d_acc_q;
    assign d_done     = d_done_q;
    assign d_rdata    = d_rdata_q;
    assign m_en       = m_en_q;
    assign m_we       = m_we_q;
    assign m_addr     = m_addr_q;
    assign m_wdata    = m_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
// with a LAT-cycle read-latency memory model on the memory port.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 17;
    localparam int LAT    = 2;

    logic              clk;
    logic              rstn;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_accepted;
    logic              i_done;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic [3:0]        d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_accepted;
    logic              d_done;
    logic [31:0]       d_rdata;
    logic              m_en;
    logic [3:0]        m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic [31:0]       m_rdata;

    int n_checks = 0;
    int n_err    = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_accepted (i_accepted),
        .i_done     (i_done),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_accepted (d_accepted),
        .d_done     (d_done),
        .d_rdata    (d_rdata),
        .m_en       (m_en),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_rdata    (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_f(input logic [ADDR_W-1:0] a);
        if (a == 17'h00010) return 32'hDEADBEEF;
        return 32'hC0DE0000 ^ {15'd0, a};
    endfunction

    // Memory model: data for an m_en in cycle c is on m_rdata during c+LAT.
    logic [31:0] pipe [0:3];
    always @(posedge clk) begin
        pipe[0] <= m_en ? mem_f(m_addr) : 32'h0;
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign m_rdata = pipe[LAT-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_iacc"},  32'(i_accepted), 32'd0);
        check({tag, "_dacc"},  32'(d_accepted), 32'd0);
        check({tag, "_idone"}, 32'(i_done),     32'd0);
        check({tag, "_ddone"}, 32'(d_done),     32'd0);
        check({tag, "_irdat"}, i_rdata,         32'd0);
        check({tag, "_drdat"}, d_rdata,         32'd0);
        check({tag, "_men"},   32'(m_en),       32'd0);
        check({tag, "_mwe"},   32'(m_we),       32'd0);
        check({tag, "_maddr"}, 32'(m_addr),     32'd0);
        check({tag, "_mwdat"}, m_wdata,         32'd0);
    endtask

    // Global watchdog: the bench must always terminate.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] prev_d;
        logic [ADDR_W-1:0] iq[$];
        logic [ADDR_W-1:0] dq[$];
        logic [ADDR_W-1:0] exp_a;
        int n_done, drain, n_iacc, n_dacc, n_idone, n_ddone;
        logic have_prev, prev_port;

        rstn = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 4'b0000; d_addr = '0; d_wdata = 32'h0;
        tick();
        tick();
        check_all_zero("rst");
        rstn = 1'b1;
        tick();

        // Single instruction fetch from an idle arbiter.
        i_req = 1'b1; i_addr = 17'h00010;
        for (int k = 1; k <= 6; k++) begin
            tick();
            i_req = 1'b0;
            check("f_iacc", 32'(i_accepted), 32'(k == 1));
            check("f_men",  32'(m_en),       32'(k == 2));
            check("f_idone", 32'(i_done),    32'(k == 5));
            if (k == 2) begin
                check("f_maddr", 32'(m_addr), 32'h00010);
                check("f_mwe",   32'(m_we),   32'd0);
            end
            if (k == 5) check("f_irdata", i_rdata, 32'hDEADBEEF);
        end

        // Simultaneous requests after reset: data wins, then the next tie goes to instruction.
        do_reset();
        i_req = 1'b1; i_addr = 17'h00020;
        d_req = 1'b1; d_addr = 17'h00040; d_we = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            i_req = 1'b0; d_req = 1'b0;
            check("t1_iacc", 32'(i_accepted), 32'(k == 1));
            check("t1_dacc", 32'(d_accepted), 32'(k == 1));
            check("t1_men",  32'(m_en),       32'(k == 2 || k == 6));
            check("t1_ddone", 32'(d_done),    32'(k == 5));
            check("t1_idone", 32'(i_done),    32'(k == 9));
            if (k == 2) check("t1_maddr_d", 32'(m_addr), 32'h00040);
            if (k == 6) check("t1_maddr_i", 32'(m_addr), 32'h00020);
            if (k == 5) check("t1_drdata", d_rdata, mem_f(17'h00040));
            if (k == 9) check("t1_irdata", i_rdata, mem_f(17'h00020));
        end
        i_req = 1'b1; i_addr = 17'h00030;
        d_req = 1'b1; d_addr = 17'h00050;
        for (int k = 1; k <= 10; k++) begin
            tick();
            i_req = 1'b0; d_req = 1'b0;
            if (k == 2) check("t2_maddr_i", 32'(m_addr), 32'h00030);
            if (k == 6) check("t2_maddr_d", 32'(m_addr), 32'h00050);
            if (k == 9) check("t2_ddone", 32'(d_done), 32'd1);
        end

        // Partial-word store: write latency 3, load data register untouched.
        prev_d = mem_f(17'h00050);
        d_req = 1'b1; d_we = 4'b0011; d_addr = 17'h00100; d_wdata = 32'h12345678;
        for (int k = 1; k <= 4; k++) begin
            tick();
            d_req = 1'b0; d_we = 4'b0000;
            check("w_dacc",  32'(d_accepted), 32'(k == 1));
            check("w_men",   32'(m_en),       32'(k == 2));
            check("w_ddone", 32'(d_done),     32'(k == 3));
            if (k == 2) begin
                check("w_mwe",   32'(m_we),   32'h3);
                check("w_maddr", 32'(m_addr), 32'h00100);
                check("w_mwdat", m_wdata,     32'h12345678);
            end
            if (k == 3) check("w_drdata", d_rdata, prev_d);
        end

        // Repeated fetch requests while the first is buffered/in flight are ignored.
        i_req = 1'b1; i_addr = 17'h00060;
        n_idone = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            i_req = (k == 1 || k == 3);
            i_addr = 17'h00070;
            if (i_done) n_idone++;
            check("rep_iacc", 32'(i_accepted), 32'(k == 1));
            if (k == 5) check("rep_irdata", i_rdata, mem_f(17'h00060));
        end
        i_req = 1'b0;
        check("rep_ndone", 32'(n_idone), 32'd1);

        // Reset one cycle after the memory strobe of a read aborts it.
        i_req = 1'b1; i_addr = 17'h00080;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 1) i_req = 1'b0;
            if (k == 3) begin rstn = 1'b0; i_req = 1'b1; end
            if (k == 5) begin rstn = 1'b1; i_req = 1'b0; end
            check("ra_idone", 32'(i_done), 32'd0);
            if (k == 2) check("ra_men", 32'(m_en), 32'd1);
            if (k == 4 || k == 5) check_all_zero("ra");
            if (k >= 4) check("ra_iacc", 32'(i_accepted), 32'd0);
        end
        i_req = 1'b1; i_addr = 17'h00090;
        for (int k = 1; k <= 6; k++) begin
            tick();
            i_req = 1'b0;
            check("rf_idone", 32'(i_done), 32'(k == 5));
            if (k == 5) check("rf_irdata", i_rdata, mem_f(17'h00090));
        end

        // Continuous load on both ports: grants alternate, one accept and one done per request.
        n_done = 0; drain = 0; n_iacc = 0; n_dacc = 0; n_idone = 0; n_ddone = 0;
        have_prev = 1'b0; prev_port = 1'b0;
        i_req = 1'b1; i_addr = 17'h01000;
        d_req = 1'b1; d_addr = 17'h02000; d_we = 4'b0000;
        for (int c = 0; c < 400 && drain < 20; c++) begin
            tick();
            if (i_accepted) begin
                iq.push_back(i_addr); n_iacc++; i_addr = i_addr + 17'd1;
            end
            if (d_accepted) begin
                dq.push_back(d_addr); n_dacc++; d_addr = d_addr + 17'd1;
            end
            if (m_en) begin
                if (have_prev) check("cl_alt", 32'(m_addr[13]), 32'(!prev_port));
                prev_port = m_addr[13];
                have_prev = 1'b1;
            end
            if (i_done && d_done) check("cl_two_done", 32'd1, 32'd0);
            if (i_done) begin
                n_done++; n_idone++;
                exp_a = (iq.size() > 0) ? iq.pop_front() : '1;
                check("cl_irdata", i_rdata, mem_f(exp_a));
            end
            if (d_done) begin
                n_done++; n_ddone++;
                exp_a = (dq.size() > 0) ? dq.pop_front() : '1;
                check("cl_drdata", d_rdata, mem_f(exp_a));
            end
            if (n_done >= 20) begin
                i_req = 1'b0; d_req = 1'b0; drain++;
            end
        end
        check("cl_ndone",  32'(n_done >= 20), 32'd1);
        check("cl_i_bal",  32'(n_idone), 32'(n_iacc));
        check("cl_d_bal",  32'(n_ddone), 32'(n_dacc));
        check("cl_i_left", 32'(iq.size()), 32'd0);
        check("cl_d_left", 32'(dq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
